imem_prog: RTL and testbench

Parametrised successor to the fixed 128×32 instruction ROM: a single-port instruction memory whose depth and word width are parameters, and which can be reprogrammed at run time from a byte stream, e.g. a UART receiver on the FPGA board. No re-synthesis is needed to change the program. The fetch port keeps the original combinational, zero-latency read, so the single-cycle/pipelined ARM datapath connects unchanged. While a load is in progress the fetch port returns a NOP and `busy` holds the core.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_byte_assembler.sv | 52 +++++
 rtl/imem_prog.sv | 112 +++++++++++
 tb/tb_imem_prog.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the reprogrammable instruction memory.
// Holds the load FSM state type, the default NOP encoding and word geometry helpers.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } imem_state_t;

  // ADD XZR,XZR,XZR: harmless filler fetched while the memory is being rewritten
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h8b1f03ff;

  function automatic int bytes_per_word(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs a little-endian byte stream into N-bit words; emits a word when it fills
// or when a flush arrives with a partial word pending (unfilled bytes are zero).
module imem_byte_assembler
  import imem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         flush,
  input  logic         clear,
  output logic [N-1:0] word,
  output logic         word_valid,
  output logic         nonempty
);

  localparam int BPW = bytes_per_word(N);
  localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [KW-1:0] LAST = KW'(BPW - 1);

  logic [KW-1:0] k;
  logic [N-1:0]  acc;
  logic [N-1:0]  merged;
  logic          full;

  // The incoming byte is merged combinationally so a full or flushed word can be written on the same edge
  always_comb begin
    merged = acc;
    if (byte_valid) merged = acc | (N'(byte_data) << {k, 3'b000});
  end

  assign full       = byte_valid && (k == LAST);
  assign nonempty   = (k != '0);
  assign word_valid = full || (flush && (nonempty || byte_valid));
  assign word       = merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k   <= '0;
      acc <= '0;
    end else if (clear || flush || full) begin
      k   <= '0;
      acc <= '0;
    end else if (byte_valid) begin
      k   <= k + 1'b1;
      acc <= merged;
    end
  end

endmodule

// File: rtl/imem_prog.sv
// Instruction memory with a zero-latency fetch port that can be reloaded at run time
// from a byte stream; fetches return NOP_WORD and busy stalls the core while loading.
module imem_prog
  import imem_pkg::*;
#(
  parameter int N                 = 32,
  parameter int DEPTH             = 128,
  parameter int ADDR_W            = $clog2(DEPTH),
  parameter logic [N-1:0] NOP_WORD = N'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q,
  input  logic              prog_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              prog_end,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);

  imem_state_t state, next_state;

  logic [N-1:0]    mem [DEPTH];
  logic [ADDR_W:0] ptr;
  logic            in_load;
  logic            room;
  logic            start_load;
  logic            asm_valid;
  logic            asm_flush;
  logic [N-1:0]    asm_word;
  logic            asm_word_valid;
  logic            asm_nonempty;
  logic            write_en;

  assign in_load    = (state == LOAD);
  assign room       = (ptr < DEPTH_P);
  assign start_load = (state == IDLE) && prog_start;
  assign asm_valid  = in_load && byte_valid && room;
  assign asm_flush  = in_load && prog_end;
  assign write_en   = in_load && asm_word_valid && room;

  imem_byte_assembler #(.N(N)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (asm_valid),
    .byte_data  (byte_data),
    .flush      (asm_flush),
    .clear      (start_load),
    .word       (asm_word),
    .word_valid (asm_word_valid),
    .nonempty   (asm_nonempty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (prog_start) next_state = LOAD;
      LOAD: begin
        busy = 1'b1;
        if (prog_end) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The pointer doubles as the words_loaded count, including a padded final word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      overflow <= 1'b0;
    end else if (start_load) begin
      ptr      <= '0;
      overflow <= 1'b0;
    end else begin
      if (write_en) ptr <= ptr + 1'b1;
      if (in_load && byte_valid && !room) overflow <= 1'b1;
    end
  end

  assign words_loaded = ptr;

  // Memory is deliberately left out of reset so a core reset keeps the program
  always_ff @(posedge clk) begin
    if (write_en) mem[ptr[ADDR_W-1:0]] <= asm_word;
  end

  always_comb begin
    if (busy)                     q = NOP_WORD;
    else if ({1'b0, addr} < DEPTH_P) q = mem[addr];
    else                          q = '0;
  end

  assert property (@(posedge clk) disable iff (!reset) asm_nonempty |-> room);

endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench: three memories (128, 4 and 6 words) share one byte stream and are
// compared every cycle against a queue-style load model, plus hand-computed expectations.
module tb_imem_prog;

  localparam logic [31:0] NOP = 32'h8b1f03ff;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_start, byte_valid, prog_end;
  logic [7:0] byte_data;
  logic [6:0] addr;

  logic [31:0] q_a, q_b, q_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [7:0]  wl_a;
  logic [2:0]  wl_b;
  logic [3:0]  wl_c;

  int total = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  imem_prog #(.DEPTH(128)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .q(q_a), .prog_start(prog_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .prog_end(prog_end),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .words_loaded(wl_a)
  );

  imem_prog #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .addr(addr[1:0]), .q(q_b), .prog_start(prog_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .prog_end(prog_end),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .words_loaded(wl_b)
  );

  imem_prog #(.DEPTH(6)) dut_c (
    .clk(clk), .reset(reset), .addr(addr[2:0]), .q(q_c), .prog_start(prog_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .prog_end(prog_end),
    .busy(busy_c), .done(done_c), .overflow(ovf_c), .words_loaded(wl_c)
  );

  // Reference model: 0 idle, 1 loading, 2 done; bytes pile into cur until a word is complete
  int          depth [3] = '{128, 4, 6};
  int          amask [3] = '{127, 3, 7};
  int          mst   [3];
  int          nb    [3];
  int          mptr  [3];
  bit          movf  [3];
  logic [31:0] cur   [3];
  logic [31:0] mem_m [3][128];

  initial begin
    for (int d = 0; d < 3; d++) begin
      mst[d] = 0; nb[d] = 0; mptr[d] = 0; movf[d] = 0; cur[d] = '0;
      for (int i = 0; i < 128; i++) mem_m[d][i] = '0;
    end
  end

  task automatic model_step(input int d);
    case (mst[d])
      0: if (prog_start) begin
        mst[d] = 1; mptr[d] = 0; movf[d] = 0; nb[d] = 0; cur[d] = '0;
      end
      1: begin
        if (byte_valid) begin
          if (mptr[d] == depth[d]) movf[d] = 1;
          else begin
            cur[d][8*nb[d] +: 8] = byte_data;
            nb[d]++;
            if (nb[d] == 4) begin
              mem_m[d][mptr[d]] = cur[d];
              mptr[d]++; nb[d] = 0; cur[d] = '0;
            end
          end
        end
        if (prog_end) begin
          if (nb[d] != 0) begin
            mem_m[d][mptr[d]] = cur[d];
            mptr[d]++; nb[d] = 0; cur[d] = '0;
          end
          mst[d] = 2;
        end
      end
      default: mst[d] = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        mst[d] = 0; nb[d] = 0; mptr[d] = 0; movf[d] = 0; cur[d] = '0;
      end else begin
        model_step(d);
      end
    end
  end

  function automatic logic [31:0] exp_q(input int d);
    int idx;
    idx = int'(addr) & amask[d];
    if (mst[d] == 1)        return NOP;
    else if (idx < depth[d]) return mem_m[d][idx];
    else                    return 32'h0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_dut(input int d, input logic [31:0] q, input logic busy, input logic done,
                           input logic ovf, input logic [7:0] wl);
    check_output($sformatf("d%0d_q", d), q, exp_q(d));
    check_output($sformatf("d%0d_busy", d), 32'(busy), 32'(mst[d] == 1));
    check_output($sformatf("d%0d_done", d), 32'(done), 32'(mst[d] == 2));
    check_output($sformatf("d%0d_overflow", d), 32'(ovf), 32'(movf[d]));
    check_output($sformatf("d%0d_words_loaded", d), 32'(wl), 32'(mptr[d]));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut(0, q_a, busy_a, done_a, ovf_a, wl_a);
      check_dut(1, q_b, busy_b, done_b, ovf_b, 8'(wl_b));
      check_dut(2, q_c, busy_c, done_c, ovf_c, 8'(wl_c));
    end
  end

  task automatic apply_stimulus(input logic ps, input logic bv, input logic [7:0] bd,
                                input logic pe, input logic [6:0] a);
    prog_start = ps; byte_valid = bv; byte_data = bd; prog_end = pe; addr = a;
    @(posedge clk); #1;
    prog_start = 1'b0; byte_valid = 1'b0; prog_end = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  logic [7:0] two_word [8] = '{8'hff, 8'h03, 8'h1f, 8'h8b, 8'h01, 8'h00, 8'h00, 8'hf8};
  logic [7:0] six_byte [6] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h11, 8'h22};

  initial begin
    reset = 1'b0; prog_start = 1'b0; byte_valid = 1'b0; prog_end = 1'b0;
    byte_data = 8'h00; addr = 7'd5;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check_output("reset_q", q_a, 32'h0);
    check_output("reset_busy", 32'(busy_a), 32'h0);
    check_output("reset_done", 32'(done_a), 32'h0);
    check_output("reset_words_loaded", 32'(wl_a), 32'h0);
    reset = 1'b1;
    apply_stimulus(0, 0, 8'h00, 0, 7'd5);

    // Two full words
    apply_stimulus(1, 0, 8'h00, 0, 7'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 1, two_word[i], 0, 7'(i));
    apply_stimulus(0, 0, 8'h00, 1, 7'd1);
    check_output("two_word_done", 32'(done_a), 32'h1);
    check_output("two_word_q1", q_a, 32'hf8000001);
    check_output("two_word_words_loaded", 32'(wl_a), 32'd2);
    check_output("model_mem0_pin", mem_m[0][0], 32'h8b1f03ff);
    apply_stimulus(0, 0, 8'h00, 0, 7'd0);
    check_output("two_word_done_once", 32'(done_a), 32'h0);
    check_output("two_word_q0", q_a, 32'h8b1f03ff);

    // Partial word with the last byte arriving alongside prog_end
    apply_stimulus(1, 0, 8'h00, 0, 7'd0);
    apply_stimulus(0, 1, 8'he6, 0, 7'd0);
    apply_stimulus(0, 1, 8'h03, 0, 7'd0);
    apply_stimulus(0, 1, 8'h01, 1, 7'd0);
    check_output("partial_q0", q_a, 32'h000103e6);
    check_output("partial_words_loaded", 32'(wl_a), 32'd1);
    apply_stimulus(0, 0, 8'h00, 0, 7'd0);

    // Reset in the middle of a load keeps already-written words
    apply_stimulus(1, 0, 8'h00, 0, 7'd0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1, six_byte[i], 0, 7'd3);
    reset = 1'b0;
    #1;
    check_output("midreset_busy", 32'(busy_a), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    addr = 7'd0;
    #1;
    check_output("midreset_no_done", 32'(done_a), 32'h0);
    check_output("midreset_q0", q_a, 32'hddccbbaa);
    addr = 7'd1;
    #1;
    check_output("midreset_q1_old", q_a, 32'hf8000001);
    apply_stimulus(0, 0, 8'h00, 0, 7'd1);

    // Overflow: 17 bytes into the 4-word memory
    apply_stimulus(1, 0, 8'h00, 0, 7'd0);
    for (int i = 0; i < 17; i++) apply_stimulus(0, 1, 8'h10 + 8'(i), 0, 7'd0);
    apply_stimulus(0, 0, 8'h00, 1, 7'd0);
    check_output("ovf_flag", 32'(ovf_b), 32'h1);
    check_output("ovf_words_loaded", 32'(wl_b), 32'd4);
    check_output("ovf_mem0_kept", q_b, 32'h13121110);
    check_output("ovf_big_words_loaded", 32'(wl_c), 32'd5);
    check_output("ovf_big_flag", 32'(ovf_c), 32'h0);
    apply_stimulus(0, 0, 8'h00, 0, 7'd6);
    check_output("oob_fetch_zero", q_c, 32'h0);

    // Address sweep while loading, with a stray prog_start midway
    apply_stimulus(1, 0, 8'h00, 0, 7'd0);
    for (int a = 0; a < 128; a++) begin
      apply_stimulus(a == 40, a % 2 == 0, 8'($urandom), 0, 7'(a));
      if (a == 77) check_output("sweep_q_nop", q_a, NOP);
    end
    apply_stimulus(0, 0, 8'h00, 1, 7'd0);
    check_output("sweep_words_loaded", 32'(wl_a), 32'd16);

    // Randomized loads, gaps, stray controls and occasional resets
    for (int it = 0; it < 40; it++) begin
      int nbytes;
      bit end_with_byte;
      for (int g = $urandom_range(0, 3); g > 0; g--)
        apply_stimulus($urandom_range(0, 9) == 0, $urandom_range(0, 1), 8'($urandom),
                       $urandom_range(0, 3) == 0, 7'($urandom_range(0, 127)));
      apply_stimulus(1, 0, 8'h00, 0, 7'($urandom_range(0, 127)));
      nbytes = $urandom_range(0, 30);
      end_with_byte = (nbytes > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < nbytes; i++) begin
        if ($urandom_range(0, 2) == 0)
          apply_stimulus($urandom_range(0, 19) == 0, 0, 8'h00, 0, 7'($urandom_range(0, 127)));
        if (i == nbytes - 1 && end_with_byte)
          apply_stimulus(0, 1, 8'($urandom), 1, 7'($urandom_range(0, 127)));
        else
          apply_stimulus(0, 1, 8'($urandom), 0, 7'($urandom_range(0, 127)));
        if (it % 13 == 5 && i == nbytes / 2) pulse_reset();
      end
      if (!end_with_byte) apply_stimulus(0, 0, 8'h00, 1, 7'($urandom_range(0, 127)));
      for (int a = 0; a < 4; a++) apply_stimulus(0, 0, 8'h00, 0, 7'($urandom_range(0, 127)));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
